multi_core_power_manager: RTL and testbench

Per-core power and clock management for the multi-core cluster; the power-sequencing successor to the cluster management layer. It is parametrised in core count, idle-counter width and power-up/power-down latencies. Each core runs its own state machine: ACTIVE, idle-qualified, clock-gated, powered-off, and waking. Wake-ups pass through a round-robin arbiter and are limited by a runtime active-core budget. The block sits beside the system controller and drives the per-core power and clock enables.

---
 rtl/multi_core_power_manager.sv | 197 +++++++++++++++++++
 tb/tb_multi_core_power_manager.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_core_power_manager.sv
// Per-core power/clock sequencer for the cluster.
// Idle-driven gating, arbitrated wake-ups, active-core budget.
module multi_core_power_manager #(
  parameter int NUM_CORES  = 4,
  parameter int IDLE_CNT_W = 16,
  parameter int WAKE_LAT   = 8,
  parameter int GATE_LAT   = 4,
  parameter int KEEP_CORE0 = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic [IDLE_CNT_W-1:0]            idle_threshold_i,
  input  logic [$clog2(NUM_CORES+1)-1:0]   active_budget_i,
  input  logic [NUM_CORES-1:0]             core_idle_i,
  input  logic [NUM_CORES-1:0]             wake_req_i,
  input  logic [NUM_CORES-1:0]             force_on_i,
  output logic [NUM_CORES-1:0]             power_en_o,
  output logic [NUM_CORES-1:0]             clk_en_o,
  output logic [NUM_CORES-1:0]             core_ready_o,
  output logic [3*NUM_CORES-1:0]           core_state_o,
  output logic [$clog2(NUM_CORES+1)-1:0]   active_count_o,
  output logic                             gate_event_o,
  output logic [31:0]                      sys_status_o
);

  localparam int CW   = $clog2(NUM_CORES + 1);
  localparam int PW   = $clog2(NUM_CORES);
  localparam int MAXL = (WAKE_LAT > GATE_LAT) ? WAKE_LAT : GATE_LAT;
  localparam int LW   = $clog2(MAXL + 1);
  localparam logic [IDLE_CNT_W:0] ONE_W = 1;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_WAKING  = 3'd1,
    S_ACTIVE  = 3'd2,
    S_IDLE    = 3'd3,
    S_GATING  = 3'd4
  } state_e;

  state_e                state_q [NUM_CORES];
  state_e                state_d [NUM_CORES];
  logic [IDLE_CNT_W-1:0] idle_q  [NUM_CORES];
  logic [IDLE_CNT_W-1:0] idle_d  [NUM_CORES];
  logic [LW-1:0]         lat_q   [NUM_CORES];
  logic [LW-1:0]         lat_d   [NUM_CORES];
  logic [NUM_CORES-1:0]  pend_q, pend_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic                  gate_ev_q, gate_ev_d;
  logic                  stall_q, stall_d;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         budget_eff;
  logic                  any_wake, any_gate;
  logic [NUM_CORES-1:0]  elig, mask, grant;
  logic                  found;
  logic                  wk, keep;
  logic [IDLE_CNT_W:0]   nxt_cnt;

  always_comb begin
    cnt      = '0;
    any_wake = 1'b0;
    any_gate = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (state_q[i] != S_OFF) cnt = cnt + CW'(1);
      if (state_q[i] == S_WAKING) any_wake = 1'b1;
      if (state_q[i] == S_GATING) any_gate = 1'b1;
    end
  end

  assign budget_eff = (active_budget_i == '0) ?
                      CW'(NUM_CORES) : active_budget_i;

  // Force-on requesters pre-empt plain wakes; rr order within the set.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    rr_d  = rr_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      elig[i] = (state_q[i] == S_OFF) &&
                (pend_q[i] || wake_req_i[i] || force_on_i[i]);
    end
    mask = (|(elig & force_on_i)) ? (elig & force_on_i) : elig;
    if (cnt < budget_eff) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        idx = (int'(rr_q) + k) % NUM_CORES;
        if (!found && mask[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          rr_d       = PW'((idx + 1) % NUM_CORES);
        end
      end
    end
    stall_d = (|elig) && (cnt >= budget_eff);
  end

  always_comb begin
    gate_ev_d = 1'b0;
    wk        = 1'b0;
    keep      = 1'b0;
    nxt_cnt   = '0;
    pend_d    = pend_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      state_d[i] = state_q[i];
      idle_d[i]  = idle_q[i];
      lat_d[i]   = lat_q[i];
      wk         = wake_req_i[i] || force_on_i[i];
      keep       = (i == 0) && (KEEP_CORE0 != 0);
      nxt_cnt    = {1'b0, idle_q[i]} + ONE_W;
      unique case (state_q[i])
        S_ACTIVE: begin
          if (enable_i && core_idle_i[i] && !wk && !keep &&
              idle_threshold_i != '0) begin
            state_d[i] = S_IDLE;
            idle_d[i]  = '0;
          end
        end
        S_IDLE: begin
          if (!core_idle_i[i] || wk || !enable_i ||
              idle_threshold_i == '0) begin
            state_d[i] = S_ACTIVE;
            idle_d[i]  = '0;
          end else if (nxt_cnt >= {1'b0, idle_threshold_i}) begin
            state_d[i] = S_GATING;
            lat_d[i]   = '0;
          end else begin
            idle_d[i]  = nxt_cnt[IDLE_CNT_W-1:0];
          end
        end
        S_GATING: begin
          if (wk) pend_d[i] = 1'b1;
          if (lat_q[i] == LW'(GATE_LAT - 1)) begin
            state_d[i] = S_OFF;
            gate_ev_d  = 1'b1;
          end else begin
            lat_d[i] = lat_q[i] + LW'(1);
          end
        end
        S_OFF: begin
          if (grant[i]) begin
            state_d[i] = S_WAKING;
            lat_d[i]   = '0;
            pend_d[i]  = 1'b0;
          end else if (wk) begin
            pend_d[i] = 1'b1;
          end
        end
        S_WAKING: begin
          if (lat_q[i] == LW'(WAKE_LAT - 1)) state_d[i] = S_ACTIVE;
          else lat_d[i] = lat_q[i] + LW'(1);
        end
        default: state_d[i] = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        state_q[i] <= (i == 0) ? S_ACTIVE : S_OFF;
        idle_q[i]  <= '0;
        lat_q[i]   <= '0;
      end
      pend_q    <= '0;
      rr_q      <= '0;
      gate_ev_q <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        state_q[i] <= state_d[i];
        idle_q[i]  <= idle_d[i];
        lat_q[i]   <= lat_d[i];
      end
      pend_q    <= pend_d;
      rr_q      <= rr_d;
      gate_ev_q <= gate_ev_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      power_en_o[i]   = (state_q[i] != S_OFF);
      clk_en_o[i]     = (state_q[i] == S_ACTIVE) ||
                        (state_q[i] == S_IDLE);
      core_ready_o[i] = clk_en_o[i];
      core_state_o[3*i +: 3] = state_q[i];
    end
  end

  assign active_count_o = cnt;
  assign gate_event_o   = gate_ev_q;
  assign sys_status_o   = {21'b0, stall_q, any_gate, any_wake, 8'(cnt)};

endmodule

// File: tb/tb_multi_core_power_manager.sv
// Directed bench for multi_core_power_manager (4 cores).
// Linear scenario sequence with immediate-assertion checks.
module tb_multi_core_power_manager;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] thr;
  logic [2:0]  budget;
  logic [3:0]  idle, wake, force_on;
  logic [3:0]  power_en, clk_en, ready;
  logic [11:0] core_state;
  logic [2:0]  count;
  logic        gate_ev;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;

  multi_core_power_manager #(
    .NUM_CORES(4), .IDLE_CNT_W(16), .WAKE_LAT(8),
    .GATE_LAT(4), .KEEP_CORE0(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .idle_threshold_i(thr), .active_budget_i(budget),
    .core_idle_i(idle), .wake_req_i(wake), .force_on_i(force_on),
    .power_en_o(power_en), .clk_en_o(clk_en),
    .core_ready_o(ready), .core_state_o(core_state),
    .active_count_o(count), .gate_event_o(gate_ev),
    .sys_status_o(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input int c);
    return {29'b0, core_state[3*c +: 3]};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_pwr"}, {28'b0, power_en}, 32'h1);
    chk({tag, "_clk"}, {28'b0, clk_en}, 32'h1);
    chk({tag, "_rdy"}, {28'b0, ready}, 32'h1);
    chk({tag, "_state"}, {20'b0, core_state}, 32'o0002);
    chk({tag, "_cnt"}, {29'b0, count}, 32'd1);
    chk({tag, "_gev"}, {31'b0, gate_ev}, 32'd0);
    chk({tag, "_status"}, status, 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; thr = '0; budget = '0;
    idle = '0; wake = '0; force_on = '0;

    // 1: reset
    step(); step();
    rst = 1'b0;
    chk_reset("rst");

    // 2: wake latency on core 2
    wake = 4'b0100;
    step();
    wake = '0;
    chk("wk_state", st(2), 32'd1);
    chk("wk_pwr", {28'b0, power_en}, 32'h5);
    chk("wk_clk", {28'b0, clk_en}, 32'h1);
    chk("wk_cnt", {29'b0, count}, 32'd2);
    chk("wk_status", status, 32'h102);
    repeat (7) step();
    chk("wk_still", st(2), 32'd1);
    step();
    chk("wk_active", st(2), 32'd2);
    chk("wk_clk2", {28'b0, clk_en}, 32'h5);

    // 3: idle gating, with an early idle drop first
    thr = 16'd5; idle = 4'b0100;
    step();
    chk("idl_enter", st(2), 32'd3);
    chk("idl_rdy", {28'b0, ready}, 32'h5);
    step(); step();
    idle = '0;
    step();
    chk("idl_drop", st(2), 32'd2);
    idle = 4'b0100;
    step();
    chk("idl_re", st(2), 32'd3);
    repeat (4) step();
    chk("idl_last", st(2), 32'd3);
    step();
    chk("gt_enter", st(2), 32'd4);
    chk("gt_clk", {28'b0, clk_en}, 32'h1);
    chk("gt_status", status, 32'h202);
    repeat (3) step();
    chk("gt_last", st(2), 32'd4);
    chk("gt_nogev", {31'b0, gate_ev}, 32'd0);
    step();
    chk("off_state", st(2), 32'd0);
    chk("off_gev", {31'b0, gate_ev}, 32'd1);
    chk("off_cnt", {29'b0, count}, 32'd1);
    chk("off_pwr", {28'b0, power_en}, 32'h1);
    step();
    chk("off_gev0", {31'b0, gate_ev}, 32'd0);
    idle = '0; thr = '0;

    // 4: budget stall
    do_reset();
    budget = 3'd2; wake = 4'b1110;
    step();
    wake = '0;
    chk("bs_state", {20'b0, core_state}, 32'o0012);
    chk("bs_status1", status, 32'h102);
    thr = 16'd2; idle = 4'b0010;
    step();
    chk("bs_stall", status, 32'h502);
    chk("bs_c2off", st(2), 32'd0);
    repeat (7) step();
    chk("bs_c1act", st(1), 32'd2);
    repeat (2) step();
    chk("bs_c1idl", st(1), 32'd3);
    step();
    chk("bs_c1gt", st(1), 32'd4);
    repeat (3) step();
    chk("bs_c2wait", st(2), 32'd0);
    step();
    chk("bs_c1off", st(1), 32'd0);
    chk("bs_gev", {31'b0, gate_ev}, 32'd1);
    chk("bs_status2", status, 32'h401);
    step();
    chk("bs_c2wake", st(2), 32'd1);
    chk("bs_c3off", st(3), 32'd0);
    chk("bs_cnt", {29'b0, count}, 32'd2);
    idle = '0; thr = '0; budget = '0;

    // 5: round robin, then force priority
    do_reset();
    wake = 4'b1110;
    step();
    wake = '0;
    chk("rr_g1", {20'b0, core_state}, 32'o0012);
    step();
    chk("rr_g2", {20'b0, core_state}, 32'o0112);
    step();
    chk("rr_g3", {20'b0, core_state}, 32'o1112);
    chk("rr_cnt", {29'b0, count}, 32'd4);
    do_reset();
    wake = 4'b0110; force_on = 4'b1000;
    step();
    wake = '0; force_on = '0;
    chk("fp_g1", {20'b0, core_state}, 32'o1002);
    step();
    chk("fp_g2", {20'b0, core_state}, 32'o1012);
    step();
    chk("fp_g3", {20'b0, core_state}, 32'o1112);

    // 6: wake during gating, then reset mid-waking
    do_reset();
    wake = 4'b0010;
    step();
    wake = '0;
    repeat (8) step();
    chk("wg_act", st(1), 32'd2);
    thr = 16'd1; idle = 4'b0010;
    step();
    chk("wg_idl", st(1), 32'd3);
    step();
    chk("wg_gt", st(1), 32'd4);
    idle = '0;
    step();
    wake = 4'b0010;
    step();
    wake = '0;
    chk("wg_noabort", st(1), 32'd4);
    step();
    chk("wg_gt3", st(1), 32'd4);
    step();
    chk("wg_off", st(1), 32'd0);
    chk("wg_gev", {31'b0, gate_ev}, 32'd1);
    step();
    chk("wg_grant", st(1), 32'd1);
    chk("wg_pwr", {28'b0, power_en}, 32'h3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("mrst");
    step();
    chk("mrst_hold", {20'b0, core_state}, 32'o0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
